ddrphy_wr_dp: RTL and testbench



---
 rtl/ddrphy_wr_dp.sv | 162 ++++++++++++++++
 tb/tb_ddrphy_wr_dp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddrphy_wr_dp.sv
// DDR PHY write datapath: delays DFI write data by the programmed write latency
// and produces DQ/DM beats, the DQS preamble/toggle/postamble and drive enables.
module ddrphy_wr_dp #(
   parameter int  DQ_WIDTH  = 64,
   parameter int  DM_WIDTH  = DQ_WIDTH/8,
   parameter int  DQS_WIDTH = DQ_WIDTH/8,
   parameter int  MAX_WRLAT = 8,
   localparam int LW        = $clog2(MAX_WRLAT+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LW-1:0]         cfg_wrlat,
   input  logic                  cfg_bl8,
   input  logic                  dfi_wrdata_en,
   input  logic [2*DQ_WIDTH-1:0] dfi_wrdata,
   input  logic [2*DM_WIDTH-1:0] dfi_wrdata_mask,
   output logic [DQ_WIDTH-1:0]   dq_rise,
   output logic [DQ_WIDTH-1:0]   dq_fall,
   output logic [DM_WIDTH-1:0]   dm_rise,
   output logic [DM_WIDTH-1:0]   dm_fall,
   output logic                  dq_oe,
   output logic [DQS_WIDTH-1:0]  dqs_rise,
   output logic [DQS_WIDTH-1:0]  dqs_fall,
   output logic                  dqs_oe,
   output logic [LW-1:0]         wrlat_q,
   output logic                  wr_err,
   input  logic                  wr_err_clr
);

   localparam logic [LW-1:0] WRLAT_MIN = LW'(2);
   localparam logic [LW-1:0] WRLAT_MAX = LW'(MAX_WRLAT);

   typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

   typedef struct packed {
      logic [DM_WIDTH-1:0] dm_fall;
      logic [DM_WIDTH-1:0] dm_rise;
      logic [DQ_WIDTH-1:0] dq_fall;
      logic [DQ_WIDTH-1:0] dq_rise;
   } beat_t;

   state_t               state_q, state_d;
   beat_t                in_beat, tap_beat;
   logic                 tap_en, look_en, idle;
   logic [LW-1:0]        wrlat_clamp;
   logic                 bl8_q;
   logic [1:0]           burst_cnt;

   // The output register is the last delay stage, so only MAX_WRLAT-1 data
   // stages are kept; the enable pipe keeps all MAX_WRLAT for the idle check.
   logic [MAX_WRLAT-1:0] pipe_en;
   beat_t                pipe_beat [MAX_WRLAT-1];

   assign in_beat = {dfi_wrdata_mask, dfi_wrdata};

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; the data pipe is reset too because the outputs must come
   // up clean and the pipe is small enough that this costs little.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_en <= '0;
         for (int i = 0; i < MAX_WRLAT-1; i++) pipe_beat[i] <= '0;
      end else begin
         pipe_en      <= {pipe_en[MAX_WRLAT-2:0], dfi_wrdata_en};
         pipe_beat[0] <= in_beat;
         for (int i = 1; i < MAX_WRLAT-1; i++) pipe_beat[i] <= pipe_beat[i-1];
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      tap_beat = '0;
      tap_en   = 1'b0;
      look_en  = dfi_wrdata_en;
      for (int i = 0; i < MAX_WRLAT-1; i++) begin
         if (int'(wrlat_q) == i + 2) begin
            tap_beat = pipe_beat[i];
            tap_en   = pipe_en[i];
         end
         if (int'(wrlat_q) == i + 3) look_en = pipe_en[i];
      end
   end

   always_comb begin
      wrlat_clamp = cfg_wrlat;
      if (cfg_wrlat < WRLAT_MIN)      wrlat_clamp = WRLAT_MIN;
      else if (cfg_wrlat > WRLAT_MAX) wrlat_clamp = WRLAT_MAX;
   end

   // Config may only move when nothing is in flight and no postamble is owed.
   assign idle = !dfi_wrdata_en && (pipe_en == '0) && (state_q != DATA);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrlat_q <= WRLAT_MIN;
         bl8_q   <= 1'b0;
      end else if (idle) begin
         wrlat_q <= wrlat_clamp;
         bl8_q   <= cfg_bl8;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (look_en) state_d = PRE;
         PRE:     state_d = DATA;
         DATA:    if (!tap_en) state_d = POST;
         POST:    state_d = look_en ? PRE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dq_rise  <= '0;
         dq_fall  <= '0;
         dm_rise  <= '0;
         dm_fall  <= '0;
         dq_oe    <= 1'b0;
         dqs_rise <= '0;
         dqs_fall <= '0;
         dqs_oe   <= 1'b0;
      end else begin
         dq_oe    <= (state_d == DATA);
         dqs_oe   <= (state_d != IDLE);
         dqs_rise <= (state_d == DATA) ? '1 : '0;
         dqs_fall <= '0;
         if (state_d == DATA) begin
            dq_rise <= tap_beat.dq_rise;
            dq_fall <= tap_beat.dq_fall;
            dm_rise <= tap_beat.dm_rise;
            dm_fall <= tap_beat.dm_fall;
         end else begin
            dq_rise <= '0;
            dq_fall <= '0;
            dm_rise <= '0;
            dm_fall <= '0;
         end
      end
   end

   // Burst framing: count enable cycles modulo the burst length in clk cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt <= '0;
         wr_err    <= 1'b0;
      end else begin
         if (dfi_wrdata_en) burst_cnt <= bl8_q ? burst_cnt + 2'd1 : {1'b0, ~burst_cnt[0]};
         else               burst_cnt <= '0;
         if (!dfi_wrdata_en && burst_cnt != 2'd0) wr_err <= 1'b1;
         else if (wr_err_clr)                     wr_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ddrphy_wr_dp.sv
// Self-checking bench for ddrphy_wr_dp: a cycle-history model derived from the
// latency/strobe timing rules checks every cycle, plus directed literal checks.
module tb_ddrphy_wr_dp;

   localparam int DQ  = 16;
   localparam int DM  = 2;
   localparam int DQS = 2;
   localparam int MAXW = 8;
   localparam int LW  = $clog2(MAXW+1);
   localparam int HN  = 2048;

   logic            clk, rst;
   logic [LW-1:0]   cfg_wrlat;
   logic            cfg_bl8;
   logic            dfi_wrdata_en;
   logic [2*DQ-1:0] dfi_wrdata;
   logic [2*DM-1:0] dfi_wrdata_mask;
   logic [DQ-1:0]   dq_rise, dq_fall;
   logic [DM-1:0]   dm_rise, dm_fall;
   logic            dq_oe, dqs_oe;
   logic [DQS-1:0]  dqs_rise, dqs_fall;
   logic [LW-1:0]   wrlat_q;
   logic            wr_err, wr_err_clr;

   ddrphy_wr_dp #(.DQ_WIDTH(DQ), .MAX_WRLAT(MAXW)) dut (
      .clk(clk), .rst(rst), .cfg_wrlat(cfg_wrlat), .cfg_bl8(cfg_bl8),
      .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata),
      .dfi_wrdata_mask(dfi_wrdata_mask), .dq_rise(dq_rise), .dq_fall(dq_fall),
      .dm_rise(dm_rise), .dm_fall(dm_fall), .dq_oe(dq_oe), .dqs_rise(dqs_rise),
      .dqs_fall(dqs_fall), .dqs_oe(dqs_oe), .wrlat_q(wrlat_q), .wr_err(wr_err),
      .wr_err_clr(wr_err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: per-cycle history of inputs plus the latency/burst mode in effect.
   logic            en_h  [HN];
   logic [2*DQ-1:0] d_h   [HN];
   logic [2*DM-1:0] m_h   [HN];
   int              w_h   [HN];
   logic            bl_h  [HN];
   logic            err_h [HN];
   int              cyc;
   int              run;

   function automatic logic en_at(input int k);
      return (k >= 0 && k < HN) ? en_h[k] : 1'b0;
   endfunction

   function automatic int clamp_wl(input int v);
      return (v < 2) ? 2 : (v > MAXW) ? MAXW : v;
   endfunction

   task automatic model_step();
      logic idle_c, set_c;
      int   blen;
      if (rst) begin
         cyc = 0;
         run = 0;
         foreach (en_h[i]) en_h[i] = 1'b0;
         w_h[0]   = 2;
         bl_h[0]  = 1'b0;
         err_h[0] = 1'b0;
      end else if (cyc < HN-1) begin
         en_h[cyc] = dfi_wrdata_en;
         d_h[cyc]  = dfi_wrdata;
         m_h[cyc]  = dfi_wrdata_mask;
         idle_c = !dfi_wrdata_en;
         for (int k = 1; k <= MAXW; k++) if (en_at(cyc-k)) idle_c = 1'b0;
         w_h[cyc+1]  = idle_c ? clamp_wl(int'(cfg_wrlat)) : w_h[cyc];
         bl_h[cyc+1] = idle_c ? cfg_bl8 : bl_h[cyc];
         blen  = bl_h[cyc] ? 4 : 2;
         set_c = 1'b0;
         if (dfi_wrdata_en) run++;
         else begin
            set_c = (run % blen) != 0;
            run   = 0;
         end
         err_h[cyc+1] = set_c ? 1'b1 : wr_err_clr ? 1'b0 : err_h[cyc];
         cyc++;
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   // Cycle c carries data for input cycle c-W, PRE one cycle before the first
   // data cycle, POST one cycle after the last.
   task automatic compare();
      int   c, w;
      logic dat, pre, post;
      logic [2*DQ-1:0] d;
      logic [2*DM-1:0] m;
      c    = cyc;
      w    = w_h[c];
      dat  = en_at(c-w);
      pre  = !dat && en_at(c-w+1);
      post = !dat && !pre && en_at(c-w-1);
      d    = dat ? d_h[c-w] : '0;
      m    = dat ? m_h[c-w] : '0;
      check("wrlat_q",  64'(wrlat_q), 64'(w));
      check("dq_oe",    64'(dq_oe), 64'(dat));
      check("dqs_oe",   64'(dqs_oe), 64'(dat | pre | post));
      check("dqs_rise", 64'(dqs_rise), dat ? 64'(2'b11) : 64'(0));
      check("dqs_fall", 64'(dqs_fall), 64'(0));
      check("dq_rise",  64'(dq_rise), 64'(d[DQ-1:0]));
      check("dq_fall",  64'(dq_fall), 64'(d[2*DQ-1:DQ]));
      check("dm_rise",  64'(dm_rise), 64'(m[DM-1:0]));
      check("dm_fall",  64'(dm_fall), 64'(m[2*DM-1:DM]));
      check("wr_err",   64'(wr_err), 64'(err_h[c]));
   endtask

   initial forever begin
      @(negedge clk);
      if (chk_on && !rst && cyc < HN) compare();
   end

   task automatic step(input logic en, input logic [2*DQ-1:0] d, input logic [2*DM-1:0] m);
      @(posedge clk);
      #1;
      dfi_wrdata_en   = en;
      dfi_wrdata      = d;
      dfi_wrdata_mask = m;
      wr_err_clr      = 1'b0;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0);
   endtask

   task automatic run_pattern(input logic [15:0] en_pat, input int n,
                              output logic [15:0] oe_obs, output logic [15:0] dq_obs);
      oe_obs = '0;
      dq_obs = '0;
      for (int i = 0; i < n; i++) begin
         step(en_pat[i], {16'(i*7+3), 16'(i*5+1)}, 4'b0110);
         oe_obs[i] = dqs_oe;
         dq_obs[i] = dq_oe;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [15:0] oe_obs, dq_obs;

   initial begin
      rst = 1'b1;
      cfg_wrlat = '0; cfg_bl8 = 1'b0;
      dfi_wrdata_en = 1'b0; dfi_wrdata = '0; dfi_wrdata_mask = '0; wr_err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_on = 1'b1;

      // Latency clamp: low and high out-of-range requests.
      idle_steps(3);
      check("clamp_low", 64'(wrlat_q), 64'(2));
      cfg_wrlat = 4'd15;
      idle_steps(2);
      check("clamp_high", 64'(wrlat_q), 64'(8));
      cfg_wrlat = 4'd4;
      idle_steps(2);
      check("wrlat_4", 64'(wrlat_q), 64'(4));

      // Single BL4 burst, rise mask 01 / fall mask 10.
      step(1'b1, 32'hBEEF_1234, 4'b1001);
      step(1'b1, 32'h5A5A_C3C3, 4'b1001);
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
      check("pre_dqs_oe", 64'(dqs_oe), 64'(1));
      check("pre_dq_oe",  64'(dq_oe),  64'(0));
      check("pre_dm_rise", 64'(dm_rise), 64'(0));
      step(1'b0, '0, '0);
      check("beat_a_rise", 64'(dq_rise), 64'h1234);
      check("beat_a_fall", 64'(dq_fall), 64'hBEEF);
      check("beat_a_dm_rise", 64'(dm_rise), 64'(2'b01));
      check("beat_a_dm_fall", 64'(dm_fall), 64'(2'b10));
      check("beat_a_dqs_rise", 64'(dqs_rise), 64'(2'b11));
      step(1'b0, '0, '0);
      check("beat_b_rise", 64'(dq_rise), 64'hC3C3);
      step(1'b0, '0, '0);
      check("post_dqs_oe", 64'(dqs_oe), 64'(1));
      check("post_dq_oe",  64'(dq_oe),  64'(0));
      check("post_dqs_rise", 64'(dqs_rise), 64'(0));
      step(1'b0, '0, '0);
      check("idle_dqs_oe", 64'(dqs_oe), 64'(0));
      check("single_wr_err", 64'(wr_err), 64'(0));
      idle_steps(10);

      // Back-to-back with no gap: one PRE, four DATA, one POST.
      run_pattern(16'h000F, 12, oe_obs, dq_obs);
      check("gap0_dqs_oe", 64'(oe_obs), 64'h01F8);
      check("gap0_dq_oe",  64'(dq_obs), 64'h00F0);
      idle_steps(10);

      // Bursts spaced so POST runs straight into PRE.
      run_pattern(16'h0033, 12, oe_obs, dq_obs);
      check("postpre_dqs_oe", 64'(oe_obs), 64'h07F8);
      check("postpre_dq_oe",  64'(dq_obs), 64'h0330);
      idle_steps(10);

      // Latency change mid-burst takes effect only after the pipe drains.
      step(1'b1, 32'h1111_2222, 4'b0011);
      cfg_wrlat = 4'd6;
      step(1'b1, 32'h3333_4444, 4'b1100);
      step(1'b1, 32'h5555_6666, 4'b0101);
      step(1'b1, 32'h7777_8888, 4'b1010);
      step(1'b0, '0, '0);
      check("latch_hold", 64'(wrlat_q), 64'(4));
      idle_steps(10);
      check("latch_update", 64'(wrlat_q), 64'(6));

      // Framing error with BL8.
      cfg_bl8 = 1'b1;
      idle_steps(2);
      repeat (3) step(1'b1, 32'hA5A5_0F0F, 4'b0000);
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
      check("err_set", 64'(wr_err), 64'(1));
      wr_err_clr = 1'b1;
      step(1'b0, '0, '0);
      check("err_clr", 64'(wr_err), 64'(0));
      idle_steps(10);
      repeat (3) step(1'b1, 32'h0F0F_A5A5, 4'b1111);
      step(1'b0, '0, '0);
      wr_err_clr = 1'b1;
      step(1'b0, '0, '0);
      check("err_set_wins", 64'(wr_err), 64'(1));
      wr_err_clr = 1'b1;
      idle_steps(10);
      for (int i = 0; i < 4; i++) step(1'b1, {16'(i+16'h100), 16'(i+16'h200)}, 4'(i));
      idle_steps(2);
      check("bl8_ok_no_err", 64'(wr_err), 64'(0));
      idle_steps(10);

      // Reset mid-burst: outputs drop asynchronously, no postamble.
      for (int i = 0; i < 4; i++) step(1'b1, {16'(i+16'hD00), 16'(i+16'hE00)}, 4'b0110);
      idle_steps(3);
      check("pre_reset_dq_oe", 64'(dq_oe), 64'(1));
      #2 rst = 1'b1;
      #1;
      check("rst_dq_oe",    64'(dq_oe), 64'(0));
      check("rst_dqs_oe",   64'(dqs_oe), 64'(0));
      check("rst_dq_rise",  64'(dq_rise), 64'(0));
      check("rst_dq_fall",  64'(dq_fall), 64'(0));
      check("rst_dm",       64'({dm_rise, dm_fall}), 64'(0));
      check("rst_dqs",      64'({dqs_rise, dqs_fall}), 64'(0));
      check("rst_wrlat_q",  64'(wrlat_q), 64'(2));
      check("rst_wr_err",   64'(wr_err), 64'(0));
      dfi_wrdata_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      check("post_rst_wrlat", 64'(wrlat_q), 64'(2));
      step(1'b0, '0, '0);
      check("first_idle_load", 64'(wrlat_q), 64'(6));

      for (int i = 0; i < 4; i++) step(1'b1, {16'(i*3+16'h40), 16'(i*9+16'h80)}, 4'(i+1));
      idle_steps(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
